// File: rtl/lsu_bus_adapter_pkg.sv
// Shared encodings and window defaults for the LSU bus adapter.
package lsu_bus_adapter_pkg;

  localparam int unsigned LSOP_STORE  = 3;
  localparam int unsigned LSOP_SIGNED = 2;
  localparam logic [1:0]  LSOP_SIZE_D = 2'd3;

  localparam logic [31:0] LSU_DM_BASE  = 32'h0000_0000;
  localparam logic [31:0] LSU_DM_LIMIT = 32'h0000_2FFF;
  localparam logic [31:0] LSU_IO_BASE  = 32'h0000_7F00;
  localparam logic [31:0] LSU_IO_LIMIT = 32'h0000_7F2B;

  typedef enum logic [2:0] {
    LSU_IDLE,
    LSU_REQ0,
    LSU_WAIT0,
    LSU_REQ1,
    LSU_WAIT1,
    LSU_RESP
  } lsu_state_t;

  function automatic logic [3:0] lsop_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/lsu_bus_adapter_if.sv
// MEM-stage request/response channel and data-bus beat channel of the LSU adapter.
interface lsu_bus_adapter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_W-1:0]     req_addr;
  logic [3:0]            req_op;
  logic [DATA_W-1:0]     req_wdata;
  logic                  resp_valid;
  logic [DATA_W-1:0]     resp_rdata;
  logic                  resp_exc;
  logic                  bus_req;
  logic                  bus_gnt;
  logic [ADDR_W-1:0]     bus_addr;
  logic                  bus_we;
  logic [DATA_W/8-1:0]   bus_byteen;
  logic [DATA_W-1:0]     bus_wdata;
  logic                  bus_rvalid;
  logic [DATA_W-1:0]     bus_rdata;

  modport slave (
    input  req_valid, req_addr, req_op, req_wdata, bus_gnt, bus_rvalid, bus_rdata,
    output req_ready, resp_valid, resp_rdata, resp_exc,
           bus_req, bus_addr, bus_we, bus_byteen, bus_wdata
  );

  modport master (
    output req_valid, req_addr, req_op, req_wdata, bus_gnt, bus_rvalid, bus_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_exc,
           bus_req, bus_addr, bus_we, bus_byteen, bus_wdata
  );
endinterface

// File: rtl/lsu_bus_adapter_extend.sv
// Load-data lane shift, truncation to the access size and sign/zero extension.
module lsu_extend
  import lsu_bus_adapter_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  localparam int unsigned LANE_W = $clog2(DATA_W/8)
) (
  input  logic [DATA_W-1:0] data,
  input  logic [LANE_W-1:0] lane,
  input  logic [1:0]        size,
  input  logic              sext,
  output logic [DATA_W-1:0] result
);
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] keep;
  logic              msb;

  always_comb begin
    shifted = data >> {lane, 3'b000};
    if (lsop_bytes(size) >= 4'(DATA_W/8))
      keep = '1;
    else
      keep = (DATA_W'(1) << {lsop_bytes(size), 3'b000}) - 1'b1;
    msb    = |(shifted & (keep ^ (keep >> 1)));
    result = (shifted & keep) | ((sext && msb) ? ~keep : '0);
  end
endmodule

// File: rtl/lsu_bus_adapter.sv
// Sequential LSU-to-bus adapter, one outstanding request.
// Optional LSU_MISALIGN_SPLIT_EN: misaligned DM accesses served in one or two beats.
module lsu_bus_adapter
  import lsu_bus_adapter_pkg::*;
#(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] DM_BASE  = ADDR_W'(LSU_DM_BASE),
  parameter logic [ADDR_W-1:0] DM_LIMIT = ADDR_W'(LSU_DM_LIMIT),
  parameter logic [ADDR_W-1:0] IO_BASE  = ADDR_W'(LSU_IO_BASE),
  parameter logic [ADDR_W-1:0] IO_LIMIT = ADDR_W'(LSU_IO_LIMIT)
) (
  input logic              clk,
  input logic              reset_n,
  lsu_bus_adapter_if.slave lsu
);
  localparam int unsigned NB        = DATA_W/8;
  localparam int unsigned LANE_W    = $clog2(NB);
  localparam int unsigned BE2_W     = 2*NB;
  localparam int unsigned WD2_W     = 2*DATA_W;
  localparam logic [1:0]  FULL_SIZE = 2'(LANE_W);

  lsu_state_t        state;
  logic [LANE_W-1:0] lane_q;
  logic [1:0]        size_q;
  logic              sext_q, store_q, split_q;
  logic [NB-1:0]     be1_q;
  logic [DATA_W-1:0] wd1_q, rdata0_q;

  logic [1:0]        size_in;
  logic [3:0]        bytes_in;
  logic [LANE_W-1:0] lane_in;
  logic [ADDR_W-1:0] last_in;
  logic [BE2_W-1:0]  be_in;
  logic [WD2_W-1:0]  wd_in;
  logic              dm_ok, io_ok, misalign, split_in, exc_in;
  logic [DATA_W-1:0] ext_data, ext_result;
  logic [LANE_W-1:0] ext_lane;

  // Enables and store data are built two beats wide; the upper half feeds beat 1 of a split.
  always_comb begin
    size_in  = lsu.req_op[1:0];
    bytes_in = lsop_bytes(size_in);
    lane_in  = lsu.req_addr[LANE_W-1:0];
    last_in  = lsu.req_addr + ADDR_W'(bytes_in) - ADDR_W'(1);
    be_in    = ((BE2_W'(1) << bytes_in) - 1'b1) << lane_in;
    wd_in    = WD2_W'(lsu.req_wdata) << {lane_in, 3'b000};
    dm_ok    = ((lsu.req_addr - DM_BASE) <= (DM_LIMIT - DM_BASE)) &&
               ((last_in - DM_BASE) <= (DM_LIMIT - DM_BASE));
    io_ok    = ((lsu.req_addr - IO_BASE) <= (IO_LIMIT - IO_BASE)) &&
               ((last_in - IO_BASE) <= (IO_LIMIT - IO_BASE));
    misalign = |(lsu.req_addr[2:0] & 3'(bytes_in - 4'd1));
`ifdef LSU_MISALIGN_SPLIT_EN
    split_in = (4'(lane_in) + bytes_in) > 4'(NB);
    exc_in   = !(dm_ok || io_ok) || (misalign && !dm_ok) ||
               (io_ok && (size_in < FULL_SIZE)) || ((DATA_W == 32) && (size_in == LSOP_SIZE_D));
`else
    split_in = 1'b0;
    exc_in   = !(dm_ok || io_ok) || misalign ||
               (io_ok && (size_in < FULL_SIZE)) || ((DATA_W == 32) && (size_in == LSOP_SIZE_D));
`endif
    ext_data = split_q ? DATA_W'({lsu.bus_rdata, rdata0_q} >> {lane_q, 3'b000}) : lsu.bus_rdata;
    ext_lane = split_q ? '0 : lane_q;
  end

  lsu_extend #(.DATA_W(DATA_W)) u_extend (
    .data   (ext_data),
    .lane   (ext_lane),
    .size   (size_q),
    .sext   (sext_q),
    .result (ext_result)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= LSU_IDLE;
      lsu.req_ready  <= 1'b1;
      lsu.resp_valid <= 1'b0;
      lsu.resp_rdata <= '0;
      lsu.resp_exc   <= 1'b0;
      lsu.bus_req    <= 1'b0;
      lsu.bus_we     <= 1'b0;
      lsu.bus_byteen <= '0;
      lsu.bus_addr   <= '0;
      lsu.bus_wdata  <= '0;
      lane_q         <= '0;
      size_q         <= '0;
      sext_q         <= 1'b0;
      store_q        <= 1'b0;
      split_q        <= 1'b0;
      be1_q          <= '0;
      wd1_q          <= '0;
      rdata0_q       <= '0;
    end else begin
      lsu.resp_valid <= 1'b0;
      case (state)
        LSU_IDLE: if (lsu.req_valid) begin
          lsu.req_ready <= 1'b0;
          lane_q        <= lane_in;
          size_q        <= size_in;
          sext_q        <= lsu.req_op[LSOP_SIGNED];
          store_q       <= lsu.req_op[LSOP_STORE];
          split_q       <= split_in;
          be1_q         <= be_in[BE2_W-1:NB];
          wd1_q         <= wd_in[WD2_W-1:DATA_W];
          if (exc_in) begin
            state          <= LSU_RESP;
            lsu.resp_valid <= 1'b1;
            lsu.resp_exc   <= 1'b1;
            lsu.resp_rdata <= '0;
          end else begin
            state          <= LSU_REQ0;
            lsu.bus_req    <= 1'b1;
            lsu.bus_addr   <= {lsu.req_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
            lsu.bus_we     <= lsu.req_op[LSOP_STORE];
            lsu.bus_byteen <= be_in[NB-1:0];
            lsu.bus_wdata  <= wd_in[DATA_W-1:0];
          end
        end
        LSU_REQ0, LSU_REQ1: if (lsu.bus_gnt) begin
          lsu.bus_req <= 1'b0;
          state       <= (state == LSU_REQ0) ? LSU_WAIT0 : LSU_WAIT1;
        end
        LSU_WAIT0, LSU_WAIT1: if (lsu.bus_rvalid) begin
          if (state == LSU_WAIT0 && split_q) begin
            rdata0_q       <= lsu.bus_rdata;
            state          <= LSU_REQ1;
            lsu.bus_req    <= 1'b1;
            lsu.bus_addr   <= lsu.bus_addr + ADDR_W'(NB);
            lsu.bus_byteen <= be1_q;
            lsu.bus_wdata  <= wd1_q;
          end else begin
            state          <= LSU_RESP;
            lsu.resp_valid <= 1'b1;
            lsu.resp_exc   <= 1'b0;
            lsu.resp_rdata <= store_q ? '0 : ext_result;
          end
        end
        LSU_RESP: begin
          state          <= LSU_IDLE;
          lsu.req_ready  <= 1'b1;
          lsu.resp_exc   <= 1'b0;
          lsu.resp_rdata <= '0;
        end
        default: begin
          state         <= LSU_IDLE;
          lsu.req_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_bus_adapter.sv
// Randomized self-checking bench for lsu_bus_adapter against a byte-level reference model.
module tb_lsu_bus_adapter;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned NB = DW/8;
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  lsu_bus_adapter_if #(.ADDR_W(AW), .DATA_W(DW)) lsu ();
  lsu_bus_adapter #(.DATA_W(DW), .ADDR_W(AW)) dut (.clk(clk), .reset_n(reset_n), .lsu(lsu));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  // Reference: each accessed byte lands in beat (byte_addr/NB - addr/NB) at lane byte_addr%NB.
  task automatic model(input logic [31:0] addr, input logic [3:0] op, input logic [31:0] wd,
                       input logic [31:0] rd0, input logic [31:0] rd1,
                       output bit exc, output int nbeats, output logic [31:0] baddr,
                       output logic [3:0] be0, output logic [3:0] be1,
                       output logic [31:0] wd0, output logic [31:0] wd1, output logic [31:0] res);
    longint unsigned a, last, ab;
    int bytes, lane, b, l;
    bit in_dm, in_io, mis;
    logic [63:0] val, bt;
    a     = 64'(addr);
    bytes = 1 << op[1:0];
    lane  = int'(addr % NB);
    last  = a + 64'(bytes) - 1;
    in_dm = last <= 64'h2FFF;
    in_io = (a >= 64'h7F00) && (last <= 64'h7F2B);
    mis   = (addr % bytes) != 0;
    exc   = !(in_dm || in_io) || (in_io && bytes < NB) || (bytes > NB) || (mis && !(SPLIT && in_dm));
    baddr = addr & ~32'(NB - 1);
    be0 = '0; be1 = '0; val = '0; nbeats = 1;
    for (int i = 0; i < bytes && i < 8; i++) begin
      ab = a + 64'(i);
      b  = int'(ab / NB) - int'(a / NB);
      l  = int'(ab % NB);
      if (b == 0) begin
        be0[l] = 1'b1;
        bt = 64'((rd0 >> (8*l)) & 32'hFF);
      end else begin
        be1[l] = 1'b1;
        nbeats = 2;
        bt = 64'((rd1 >> (8*l)) & 32'hFF);
      end
      val |= bt << (8*i);
    end
    wd0 = wd << (8*lane);
    wd1 = (lane == 0) ? 32'h0 : (wd >> (8*(NB - lane)));
    if (op[3]) res = '0;
    else if (op[2] && val[8*bytes-1]) res = 32'(val | ~((64'd1 << (8*bytes)) - 64'd1));
    else res = 32'(val);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".req_ready"}, lsu.req_ready, 1);
    chk({tag, ".resp_valid"}, lsu.resp_valid, 0);
    chk({tag, ".resp_rdata"}, lsu.resp_rdata, 0);
    chk({tag, ".resp_exc"}, lsu.resp_exc, 0);
    chk({tag, ".bus_req"}, lsu.bus_req, 0);
    chk({tag, ".bus_we"}, lsu.bus_we, 0);
    chk({tag, ".bus_byteen"}, lsu.bus_byteen, 0);
    chk({tag, ".bus_addr"}, lsu.bus_addr, 0);
    chk({tag, ".bus_wdata"}, lsu.bus_wdata, 0);
  endtask

  task automatic do_req(input string tag, input logic [31:0] addr, input logic [3:0] op,
                        input logic [31:0] wd, input logic [31:0] rd0, input logic [31:0] rd1,
                        input int gdly, input int rdly, input bit early_rv, input int abort_beat);
    bit exc;
    int nbeats;
    logic [31:0] baddr, wd0, wd1, res, ew, mask;
    logic [3:0] be0, be1, ebe;
    model(addr, op, wd, rd0, rd1, exc, nbeats, baddr, be0, be1, wd0, wd1, res);
    @(negedge clk);
    chk({tag, ".ready"}, lsu.req_ready, 1);
    lsu.req_valid = 1'b1;
    lsu.req_addr  = addr;
    lsu.req_op    = op;
    lsu.req_wdata = wd;
    @(negedge clk);
    lsu.req_valid = 1'b0;
    lsu.req_addr  = $urandom;
    chk({tag, ".busy"}, lsu.req_ready, 0);
    if (exc) begin
      chk({tag, ".resp_valid"}, lsu.resp_valid, 1);
      chk({tag, ".exc"}, lsu.resp_exc, 1);
      chk({tag, ".rdata"}, lsu.resp_rdata, 0);
      chk({tag, ".no_beat"}, lsu.bus_req, 0);
    end else begin
      for (int b = 0; b < nbeats; b++) begin
        ebe  = (b == 0) ? be0 : be1;
        ew   = (b == 0) ? wd0 : wd1;
        mask = (b == 0) ? 32'hFFFF_FFFF : lanes(be1);
        chk({tag, ".bus_req"}, lsu.bus_req, 1);
        if (lsu.bus_req !== 1'b1) return;
        chk({tag, ".bus_addr"}, lsu.bus_addr, baddr + 32'(b*NB));
        chk({tag, ".byteen"}, lsu.bus_byteen, ebe);
        chk({tag, ".we"}, lsu.bus_we, op[3]);
        chk({tag, ".wdata"}, lsu.bus_wdata & mask, ew & mask);
        repeat (gdly) begin
          @(negedge clk);
          chk({tag, ".hold_req"}, lsu.bus_req, 1);
          chk({tag, ".hold_addr"}, lsu.bus_addr, baddr + 32'(b*NB));
          chk({tag, ".hold_byteen"}, lsu.bus_byteen, ebe);
          chk({tag, ".hold_wdata"}, lsu.bus_wdata & mask, ew & mask);
        end
        lsu.bus_gnt = 1'b1;
        if (early_rv) begin
          lsu.bus_rvalid = 1'b1;
          lsu.bus_rdata  = $urandom;
        end
        @(negedge clk);
        lsu.bus_gnt    = 1'b0;
        lsu.bus_rvalid = 1'b0;
        chk({tag, ".req_drop"}, lsu.bus_req, 0);
        chk({tag, ".no_early_resp"}, lsu.resp_valid, 0);
        if (b == abort_beat) begin
          reset_n = 1'b0;
          #1;
          chk_reset_outputs({tag, ".rst"});
          @(negedge clk);
          reset_n = 1'b1;
          lsu.bus_rvalid = 1'b1;
          lsu.bus_rdata  = $urandom;
          @(negedge clk);
          lsu.bus_rvalid = 1'b0;
          chk({tag, ".late_rvalid"}, lsu.resp_valid, 0);
          chk({tag, ".idle_ready"}, lsu.req_ready, 1);
          return;
        end
        repeat (rdly) @(negedge clk);
        lsu.bus_rvalid = 1'b1;
        lsu.bus_rdata  = (b == 0) ? rd0 : rd1;
        @(negedge clk);
        lsu.bus_rvalid = 1'b0;
        lsu.bus_rdata  = $urandom;
      end
      chk({tag, ".resp_valid"}, lsu.resp_valid, 1);
      chk({tag, ".exc"}, lsu.resp_exc, 0);
      chk({tag, ".rdata"}, lsu.resp_rdata, res);
      chk({tag, ".bus_idle"}, lsu.bus_req, 0);
    end
    @(negedge clk);
    chk({tag, ".pulse"}, lsu.resp_valid, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addr;
    lsu.req_valid  = 1'b0;
    lsu.req_addr   = '0;
    lsu.req_op     = '0;
    lsu.req_wdata  = '0;
    lsu.bus_gnt    = 1'b0;
    lsu.bus_rvalid = 1'b0;
    lsu.bus_rdata  = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    reset_n = 1'b1;

    do_req("lw_min",   32'h10,   4'b0010, 32'h0,        32'hDEADBEEF, 32'h0, 0, 0, 0, -1);
    do_req("lb",       32'h13,   4'b0100, 32'h0,        32'h80123456, 32'h0, 0, 0, 0, -1);
    do_req("lbu",      32'h13,   4'b0000, 32'h0,        32'h80123456, 32'h0, 0, 0, 0, -1);
    do_req("sh",       32'h12,   4'b1001, 32'h0000ABCD, 32'h12345678, 32'h0, 0, 0, 0, -1);
    do_req("lh_io",    32'h7F04, 4'b0001, 32'h0,        32'h0,        32'h0, 0, 0, 0, -1);
    do_req("lw_range", 32'h3000, 4'b0010, 32'h0,        32'h0,        32'h0, 0, 0, 0, -1);
    do_req("lw_mis",   32'h2,    4'b0010, 32'h0,        32'h44332211, 32'h88776655, 0, 0, 0, -1);
    do_req("sw_hold",  32'h20,   4'b1010, 32'hCAFEF00D, 32'h0,        32'h0, 5, 2, 0, -1);
    do_req("lw_early", 32'h40,   4'b0010, 32'h0,        32'h5A5AA5A5, 32'h0, 0, 1, 1, -1);
    do_req("lw_io",    32'h7F28, 4'b0010, 32'h0,        32'h01020304, 32'h0, 1, 0, 0, -1);
    do_req("lh_top",   32'h2FFE, 4'b0101, 32'h0,        32'h8001FFFF, 32'h0, 0, 0, 0, -1);
    do_req("lw_edge",  32'h2FFE, 4'b0010, 32'h0,        32'h0,        32'h0, 0, 0, 0, -1);
    do_req("ld_32",    32'h0,    4'b0011, 32'h0,        32'h0,        32'h0, 0, 0, 0, -1);
    if (SPLIT) do_req("rst_wait1", 32'h2, 4'b0010, 32'h0, 32'h11111111, 32'h22222222, 0, 0, 0, 1);
    else       do_req("rst_wait0", 32'h10, 4'b0010, 32'h0, 32'h11111111, 32'h0, 0, 0, 0, 0);
    do_req("after_rst", 32'h10,  4'b0010, 32'h0,        32'hDEADBEEF, 32'h0, 0, 0, 0, -1);

    for (int n = 0; n < 250; n++) begin
      case ($urandom_range(0, 3))
        0:       addr = $urandom_range(0, 32'h2FFF);
        1:       addr = $urandom_range(32'h2FF0, 32'h300F);
        2:       addr = $urandom_range(32'h7EF8, 32'h7F33);
        default: addr = $urandom;
      endcase
      do_req("rnd", addr, 4'($urandom_range(0, 15)), $urandom, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), -1);
      if ($urandom_range(0, 3) == 0) begin
        lsu.bus_rvalid = 1'b1;
        lsu.bus_rdata  = $urandom;
        @(negedge clk);
        lsu.bus_rvalid = 1'b0;
        chk("stray_rvalid", lsu.resp_valid, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
